// File: rtl/tdm_mux8_rr_if.sv
// -----------------------------------------------------------------------------
// tdm_mux8_rr_if
// Bundle of the eight valid/ready input lanes and the single tagged output
// stream of the 8:1 round-robin merge multiplexer.
//
//   in_data   [8*WIDTH] lane i word at bits [i*WIDTH +: WIDTH]
//   in_valid  [8]       lane i holds a word
//   in_ready  [8]       lane i word accepted this cycle (one-hot or zero)
//   y         [WIDTH]   registered output word
//   sel       [3]       registered source lane index of y
//   y_valid   [1]       y/sel valid
//   y_ready   [1]       downstream accepts y this cycle
//
// slave  : the multiplexer side
// master : the side feeding lanes and consuming the merged stream
// -----------------------------------------------------------------------------
interface tdm_mux8_rr_if #(
    parameter int WIDTH = 8
);
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   y;
    logic [2:0]         sel;
    logic               y_valid;
    logic               y_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output y,
        output sel,
        output y_valid,
        input  y_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  y,
        input  sel,
        input  y_valid,
        output y_ready
    );
endinterface

// File: rtl/tdm_mux8_rr.sv
// -----------------------------------------------------------------------------
// tdm_mux8_rr
// Eight-lane round-robin merge multiplexer. Words from the granted lane are
// captured into a single-entry output register together with their 3-bit
// source index, so the output can drive a 1:8 demux directly.
//
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : tdm_mux8_rr_if.slave (lanes in, tagged stream out)
// -----------------------------------------------------------------------------
module tdm_mux8_rr #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_mux8_rr_if.slave      bus
);
    logic [WIDTH-1:0] y_r;
    logic [2:0]       sel_r;
    logic             y_valid_r;
    logic [2:0]       ptr_r;

    logic             load_s;
    logic             any_valid_s;
    logic [2:0]       grant_idx_s;
    logic [7:0]       grant_vec_s;
    logic [WIDTH-1:0] grant_data_s;

    // Register can accept a new word when it is empty or being drained now.
    assign load_s = ~y_valid_r | bus.y_ready;

    // Round-robin search: first valid lane starting at ptr, wrapping mod 8.
    always_comb begin
        any_valid_s = 1'b0;
        grant_idx_s = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!any_valid_s && bus.in_valid[ptr_r + 3'(k)]) begin
                any_valid_s = 1'b1;
                grant_idx_s = ptr_r + 3'(k);
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // One-hot grant; forced to zero while reset is asserted.
    always_comb begin
        grant_vec_s = 8'h00;
        if (any_valid_s && load_s && rst_n) begin
            grant_vec_s[grant_idx_s] = 1'b1;
        end else begin
            grant_vec_s = 8'h00;
        end
    end

    // Granted lane's word; only feeds the register, never an output directly.
    assign grant_data_s = bus.in_data[grant_idx_s*WIDTH +: WIDTH];

    // Output register and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= '0;
            sel_r     <= 3'd0;
            y_valid_r <= 1'b0;
            ptr_r     <= 3'd0;
        end else if (load_s) begin
            if (any_valid_s) begin
                y_r       <= grant_data_s;
                sel_r     <= grant_idx_s;
                y_valid_r <= 1'b1;
                ptr_r     <= grant_idx_s + 3'd1;
            end else begin
                // Nothing to load: register empties, contents and pointer hold.
                y_valid_r <= 1'b0;
            end
        end else begin
            // Backpressure: everything holds.
            y_valid_r <= y_valid_r;
        end
    end

    assign bus.in_ready = grant_vec_s;
    assign bus.y        = y_r;
    assign bus.sel      = sel_r;
    assign bus.y_valid  = y_valid_r;

endmodule

// File: tb/tb_tdm_mux8_rr.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux8_rr
// Directed self-checking bench for tdm_mux8_rr with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_tdm_mux8_rr;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tdm_mux8_rr_if #(.WIDTH(WIDTH)) bus ();

    tdm_mux8_rr #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane i data = 0x10 + i.
    task automatic set_ramp_data();
        for (int i = 0; i < 8; i++) begin
            bus.in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
        end
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Check the whole output register plus pointer.
    task automatic check_out(input string tag, input logic [7:0] ey, input logic [2:0] es,
                             input logic ev, input logic [2:0] ep);
        check_eq({tag, ".y"},       bus.y,       64'(ey));
        check_eq({tag, ".sel"},     bus.sel,     64'(es));
        check_eq({tag, ".y_valid"}, bus.y_valid, 64'(ev));
        check_eq({tag, ".ptr"},     dut.ptr_r,   64'(ep));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 8'hFF;
        bus.y_ready   = 1'b1;
        bus.in_data   = '0;

        // Reset state, in_ready held low even with every lane valid.
        #12;
        check_out("reset", 8'h00, 3'd0, 1'b0, 3'd0);
        check_eq("reset.in_ready", bus.in_ready, 64'h00);

        // Single lane 5.
        bus.in_valid = 8'h20;
        bus.in_data[5*WIDTH +: WIDTH] = 8'hA5;
        #2 rst_n = 1'b1;
        #1;
        check_eq("single.in_ready", bus.in_ready, 64'h20);
        step();
        check_out("single", 8'hA5, 3'd5, 1'b1, 3'd6);

        // Drain to empty: y_valid falls, y/sel/ptr hold.
        bus.in_valid = 8'h00;
        #1;
        check_eq("drain.in_ready", bus.in_ready, 64'h00);
        step();
        check_out("drain", 8'hA5, 3'd5, 1'b0, 3'd6);

        // All lanes valid from ptr 0: sel 0..7,0,1 with no bubbles.
        pulse_reset();
        set_ramp_data();
        bus.in_valid = 8'hFF;
        bus.y_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("rr%0d.sel", i), bus.sel, 64'(i % 8));
            check_eq($sformatf("rr%0d.y", i), bus.y, 64'(8'h10 + 8'(i % 8)));
            check_eq($sformatf("rr%0d.y_valid", i), bus.y_valid, 64'h1);
        end
        check_eq("rr.ptr", dut.ptr_r, 64'd2);

        // Backpressure with lanes 2 and 3 valid.
        pulse_reset();
        bus.in_valid = 8'h0C;
        bus.y_ready  = 1'b0;
        #1;
        check_eq("bp.first_ready", bus.in_ready, 64'h04);
        step();
        check_out("bp.load", 8'h12, 3'd2, 1'b1, 3'd3);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("bp%0d.in_ready", i), bus.in_ready, 64'h00);
            step();
            check_out($sformatf("bp%0d", i), 8'h12, 3'd2, 1'b1, 3'd3);
        end
        bus.y_ready = 1'b1;
        #1;
        check_eq("bp.release_ready", bus.in_ready, 64'h08);
        step();
        check_out("bp.next", 8'h13, 3'd3, 1'b1, 3'd4);

        // Wrap: bring ptr to 7 via lane 6, then lanes 7 and 0.
        bus.in_valid = 8'h40;
        step();
        check_out("wrap.setup", 8'h16, 3'd6, 1'b1, 3'd7);
        bus.in_valid = 8'h81;
        step();
        check_out("wrap.l7", 8'h17, 3'd7, 1'b1, 3'd0);
        step();
        check_out("wrap.l0", 8'h10, 3'd0, 1'b1, 3'd1);
        bus.in_valid = 8'h01;
        #1;
        check_eq("wrap.scan_ready", bus.in_ready, 64'h01);
        step();
        check_out("wrap.scan", 8'h10, 3'd0, 1'b1, 3'd1);

        // Lane drops valid before grant: arbiter moves on.
        bus.in_valid = 8'h24;
        #1;
        check_eq("drop.ready_a", bus.in_ready, 64'h04);
        bus.in_valid = 8'h20;
        #1;
        check_eq("drop.ready_b", bus.in_ready, 64'h20);
        step();
        check_out("drop", 8'h15, 3'd5, 1'b1, 3'd6);

        // Reset mid-stream, asserted between edges.
        bus.in_valid = 8'hFF;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_out("midrst", 8'h00, 3'd0, 1'b0, 3'd0);
        check_eq("midrst.in_ready", bus.in_ready, 64'h00);
        #2 rst_n = 1'b1;
        step();
        check_out("midrst.first", 8'h10, 3'd0, 1'b1, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
